prbs31_checker: RTL and testbench

//  Serial PRBS31 (x^31+x^28+1) checker; the receive-side stage downstream of the prbs31 generator.

---
 rtl/prbs31_pkg.sv | 21 ++
 rtl/prbs31_checker_if.sv | 35 +++
 rtl/prbs31_lfsr.sv | 37 +++
 rtl/prbs31_checker.sv | 160 ++++++++++++++++
 tb/tb_prbs31_checker.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs31_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions for the generator and checker.
// Holds the LFSR geometry, the checker state encoding and the predicted-bit function.
package prbs31_pkg;

  localparam int PRBS31_LEN   = 31;
  localparam int PRBS31_TAP_A = 30;
  localparam int PRBS31_TAP_B = 27;

  typedef logic [PRBS31_LEN-1:0] prbs31_state_t;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic prbs31_next_bit(input prbs31_state_t s);
    return s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Serial-data and status bundle between the receive path and the PRBS31 checker.
// PRBS31_CHK_BITCNT_EN adds the bit_count status bus.
interface prbs31_checker_if #(
  parameter int ERR_CNT_W = 16
);

  logic                 din_valid;
  logic                 din;
  logic                 clear_cnt;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
`ifdef PRBS31_CHK_BITCNT_EN
  logic [31:0]          bit_count;

  modport master (
    output din_valid, din, clear_cnt,
    input  locked, err_pulse, err_count, bit_count
  );
  modport slave (
    input  din_valid, din, clear_cnt,
    output locked, err_pulse, err_count, bit_count
  );
`else
  modport master (
    output din_valid, din, clear_cnt,
    input  locked, err_pulse, err_count
  );
  modport slave (
    input  din_valid, din, clear_cnt,
    output locked, err_pulse, err_count
  );
`endif

endinterface

// File: rtl/prbs31_lfsr.sv
// 31-bit PRBS31 shift register: shifts in either an external bit (seeding) or its
// own predicted bit (free-running), only when stepped.
module prbs31_lfsr
  import prbs31_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step_i,
  input  logic load_ext_i,
  input  logic x_ext_i,
  output logic nb_o,
  output logic zero_next_o
);

  prbs31_state_t s_q, s_d;
  prbs31_state_t s_shift;
  logic          x;

  assign nb_o        = prbs31_next_bit(s_q);
  assign x           = load_ext_i ? x_ext_i : nb_o;
  assign s_shift     = {s_q[PRBS31_LEN-2:0], x};
  // Lets the checker reject an all-zero seed on the same edge that completes it.
  assign zero_next_o = (s_shift == '0);

  always_comb begin
    s_d = s_q;
    if (step_i) s_d = s_shift;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= '0;
    else     s_q <= s_d;
  end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 serial checker: seeds from the incoming stream, verifies, locks, then counts
// errors against a free-running LFSR. PRBS31_CHK_BITCNT_EN adds the locked bit counter.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter int LOCK_THRESH = 32,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  prbs31_checker_if.slave  bus
);

  localparam int SEED_W = $clog2(PRBS31_LEN);
  localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
  localparam int WIN_W  = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(PRBS31_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_THRESH - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOSS_WIN - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THRESH - 1);

  chk_state_e           state_q,    state_d;
  logic [SEED_W-1:0]    seed_cnt_q, seed_cnt_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q,  win_cnt_d;
  logic [WERR_W-1:0]    win_err_q,  win_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 locked_q,   locked_d;

  logic nb;
  logic zero_next;
  logic mismatch;
  logic load_ext;

  // Seeding and verifying follow the received stream; once locked the LFSR free-runs
  // so a single line error does not corrupt later predictions.
  assign load_ext = (state_q != LOCKED);
  assign mismatch = bus.din ^ nb;

  prbs31_lfsr u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .step_i      (bus.din_valid),
    .load_ext_i  (load_ext),
    .x_ext_i     (bus.din),
    .nb_o        (nb),
    .zero_next_o (zero_next)
  );

  // NOTE: every output of this block gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    good_cnt_d  = good_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        SEED: begin
          if (seed_cnt_q == SEED_LAST) begin
            seed_cnt_d = '0;
            if (!zero_next) begin
              state_d    = VERIFY;
              good_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            state_d    = SEED;
            seed_cnt_d = '0;
          end else if (good_cnt_q == GOOD_LAST) begin
            state_d   = LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          win_cnt_d = (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + 1'b1;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
          // Loss of lock outranks the window wrap when both land on the same bit.
          if (mismatch && (win_err_q == WERR_LAST)) begin
            state_d    = SEED;
            seed_cnt_d = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_err_d = '0;
          end else if (mismatch) begin
            win_err_d = win_err_q + 1'b1;
          end
        end
        default: state_d = SEED;
      endcase
    end

    if (bus.clear_cnt) err_cnt_d = '0;
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEED;
      seed_cnt_q  <= '0;
      good_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      good_cnt_q  <= good_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_cnt_q;

`ifdef PRBS31_CHK_BITCNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (bus.din_valid && (state_q == LOCKED) && (bit_cnt_q != '1))
      bit_cnt_d = bit_cnt_q + 1'b1;
    if (bus.clear_cnt) bit_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bit_cnt_q <= '0;
    else     bit_cnt_q <= bit_cnt_d;
  end

  assign bus.bit_count = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: a history-based reference model queues the
// expected status for every clock; a monitor pops and compares after each edge.
module tb_prbs31_checker;

  localparam int     ERR_CNT_W   = 16;
  localparam int     LOCK_THRESH = 32;
  localparam int     LOSS_WIN    = 64;
  localparam int     LOSS_THRESH = 8;
  localparam longint ERR_MAX     = (64'd1 << ERR_CNT_W) - 1;
  localparam longint BIT_MAX     = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prbs31_checker_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  prbs31_checker #(
    .ERR_CNT_W   (ERR_CNT_W),
    .LOCK_THRESH (LOCK_THRESH),
    .LOSS_WIN    (LOSS_WIN),
    .LOSS_THRESH (LOSS_THRESH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the LFSR is represented by the last 31 shifted-in bits, so the
  // predicted bit is the recurrence b[n] = b[n-31] ^ b[n-28].
  localparam int M_SEED = 0, M_VERIFY = 1, M_LOCKED = 2;
  int     m_state, m_seed_n, m_good_n, m_win_n, m_win_e;
  longint m_errc, m_bitc;
  bit     m_pulse;
  bit     m_hist[$];

  task automatic model_reset();
    m_state = M_SEED; m_seed_n = 0; m_good_n = 0; m_win_n = 0; m_win_e = 0;
    m_errc = 0; m_bitc = 0; m_pulse = 1'b0;
    m_hist.delete();
    repeat (31) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit v, input bit d, input bit clr);
    bit pred, x, all_zero;
    m_pulse = 1'b0;
    if (v) begin
      pred = m_hist[0] ^ m_hist[3];
      x    = (m_state == M_LOCKED) ? pred : d;
      void'(m_hist.pop_front());
      m_hist.push_back(x);
      case (m_state)
        M_SEED: begin
          m_seed_n++;
          if (m_seed_n == 31) begin
            m_seed_n = 0;
            all_zero = 1'b1;
            foreach (m_hist[i]) if (m_hist[i]) all_zero = 1'b0;
            if (!all_zero) begin m_state = M_VERIFY; m_good_n = 0; end
          end
        end
        M_VERIFY: begin
          if (d == pred) begin
            m_good_n++;
            if (m_good_n == LOCK_THRESH) begin m_state = M_LOCKED; m_win_n = 0; m_win_e = 0; end
          end else begin
            m_state = M_SEED; m_seed_n = 0;
          end
        end
        default: begin
          if (m_bitc < BIT_MAX) m_bitc++;
          m_win_n++;
          if (d != pred) begin
            m_pulse = 1'b1;
            if (m_errc < ERR_MAX) m_errc++;
            m_win_e++;
          end
          if (m_win_e == LOSS_THRESH) begin m_state = M_SEED; m_seed_n = 0; end
          else if (m_win_n == LOSS_WIN) begin m_win_n = 0; m_win_e = 0; end
        end
      endcase
    end
    if (clr) begin m_errc = 0; m_bitc = 0; end
  endtask

  typedef struct {
    bit     locked;
    bit     pulse;
    longint errc;
    longint bitc;
  } exp_t;
  exp_t sb_q[$];

  // Stimulus source: PRBS31 generator using the same polynomial.
  logic [30:0] gen_s;

  task automatic gen_bit(output bit b);
    b     = gen_s[30] ^ gen_s[27];
    gen_s = {gen_s[29:0], b};
  endtask

  task automatic step(input bit v, input bit d, input bit clr);
    exp_t e;
    @(negedge clk);
    rst           = 1'b0;
    bus.din_valid = v;
    bus.din       = d;
    bus.clear_cnt = clr;
    model_step(v, d, clr);
    e.locked = (m_state == M_LOCKED);
    e.pulse  = m_pulse;
    e.errc   = m_errc;
    e.bitc   = m_bitc;
    sb_q.push_back(e);
  endtask

  task automatic clean(input bit v, input bit flip, input bit clr);
    bit b;
    if (v) begin
      gen_bit(b);
      step(1'b1, b ^ flip, clr);
    end else begin
      step(1'b0, 1'($urandom), clr);
    end
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;
    bus.clear_cnt = 1'b0;
    #1;
    check("rst_locked", bus.locked, 0);
    check("rst_pulse", bus.err_pulse, 0);
    check("rst_errc", bus.err_count, 0);
    model_reset();
    e.locked = 1'b0; e.pulse = 1'b0; e.errc = 0; e.bitc = 0;
    sb_q.push_back(e);
  endtask

  task automatic probe();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every queued expectation one time unit after the edge it covers.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_locked", bus.locked, e.locked);
        check("sb_pulse", bus.err_pulse, e.pulse);
        check("sb_errc", bus.err_count, e.errc);
`ifdef PRBS31_CHK_BITCNT_EN
        check("sb_bitc", bus.bit_count, e.bitc);
`endif
      end
    end
  end

  initial begin
    int n_valid;
    bit v;
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;
    bus.clear_cnt = 1'b0;
    gen_s = '1;
    model_reset();
    do_reset();

    // Clean stream: lock exactly after 31 seed + 32 verify bits, then no errors.
    repeat (62) clean(1'b1, 1'b0, 1'b0);
    probe(); check("t1_unlocked_at_62", bus.locked, 0);
    clean(1'b1, 1'b0, 1'b0);
    probe(); check("t1_locked_at_63", bus.locked, 1);
    repeat (10000) clean(1'b1, 1'b0, 1'b0);
    probe(); check("t1_errc_clean", bus.err_count, 0);

    // Single flipped bit while locked.
    clean(1'b1, 1'b1, 1'b0);
    probe();
    check("t2_pulse", bus.err_pulse, 1);
    check("t2_errc", bus.err_count, 1);
    check("t2_locked", bus.locked, 1);
    clean(1'b1, 1'b0, 1'b0);
    probe(); check("t2_pulse_off", bus.err_pulse, 0);

    // Eight errors inside one fresh window force loss of lock, then relock.
    clean(1'b1, 1'b0, 1'b1);
    while (m_win_n != 0) clean(1'b1, 1'b0, 1'b0);
    repeat (7) clean(1'b1, 1'b1, 1'b0);
    probe(); check("t3_locked_after_7", bus.locked, 1);
    clean(1'b1, 1'b1, 1'b0);
    probe();
    check("t3_unlocked_after_8", bus.locked, 0);
    check("t3_errc", bus.err_count, 8);
    repeat (62) clean(1'b1, 1'b0, 1'b0);
    probe(); check("t3_relock_62", bus.locked, 0);
    clean(1'b1, 1'b0, 1'b0);
    probe(); check("t3_relock_63", bus.locked, 1);

    // All-zero stream never seeds.
    do_reset();
    repeat (500) step(1'b1, 1'b0, 1'b0);
    probe();
    check("t4_locked", bus.locked, 0);
    check("t4_errc", bus.err_count, 0);

    // Clear coinciding with an error: clear wins, pulse still fires.
    do_reset();
    gen_s = '1;
    repeat (63) clean(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      clean(1'b1, 1'b1, 1'b0);
      repeat (10) clean(1'b1, 1'b0, 1'b0);
    end
    probe(); check("t5_errc_5", bus.err_count, 5);
    clean(1'b1, 1'b1, 1'b1);
    probe();
    check("t5_errc_cleared", bus.err_count, 0);
    check("t5_pulse", bus.err_pulse, 1);
    check("t5_locked", bus.locked, 1);

    // Gapped stream locks at the same valid-bit count; reset mid-lock then relock.
    do_reset();
    gen_s   = '1;
    n_valid = 0;
    for (int c = 0; c < 2000; c++) begin
      v = 1'($urandom % 2);
      clean(v, 1'b0, 1'b0);
      if (v) n_valid++;
      probe();
      if (bus.locked) break;
    end
    check("t6_lock_valid_bits", n_valid, 63);
    repeat (200) clean(1'($urandom % 2), 1'b0, 1'b0);
    probe(); check("t6_locked_before_rst", bus.locked, 1);
    do_reset();
    repeat (62) clean(1'b1, 1'b0, 1'b0);
    probe(); check("t6_relock_62", bus.locked, 0);
    clean(1'b1, 1'b0, 1'b0);
    probe(); check("t6_relock_63", bus.locked, 1);

    // Random soak: gaps, sparse errors, error bursts and occasional clears.
    for (int c = 0; c < 4000; c++) begin
      clean(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 300) == 0);
      if (($urandom % 1000) == 0) repeat (12) clean(1'b1, 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
